alu_frame_engine: RTL and testbench
===================================

# alu_frame_engine

Byte-stream command engine between the UART byte interface and a combinational ALU. It assembles a received frame into two operands and an opcode, and drives the ALU with sign-extended registered operands. It captures the result and serialises it MSB-first back onto the transmit byte stream. Operand width, ALU width and an inter-byte resync timeout are parameters; the block has no vendor FIFO.

## Interface
- `OP_BYTES`, 2, bytes per received operand (≥1).
- `DW`, 32, ALU data width; multiple of 8 and ≥ 8*`OP_BYTES`.
- `TIMEOUT_CYC`, 1000, idle cycles mid-frame before the partial frame is dropped; 0 disables the timeout.
- `clk_i` in 1 clock.
- `rst_n` in 1 reset, asynchronous, active-low.
- `rx_valid_i` in 1 received byte valid.
- `rx_ready_o` out 1 engine accepts byte.
- `rx_data_i` in 8 received byte.
- `tx_valid_o` out 1 result byte valid.
- `tx_ready_i` in 1 transmitter accepts byte.
- `tx_data_o` out 8 result byte.
- `alu_a_o` out DW operand A, sign-extended.
- `alu_b_o` out DW operand B, sign-extended.
- `alu_op_o` out 3 opcode, rx byte[2:0].
- `alu_result_i` in DW ALU result (combinational from `alu_*_o`).
- `alu_flags_i` in 4 {Z,C,N,V} from ALU.
- `busy_o` out 1 high in EXEC or TX.
- `frame_drop_o` out 1 one-cycle pulse when a partial frame is discarded.
- `frame_cnt_o` out 16 completed frames, wraps 0xFFFF→0.

## Operation
- Frame: `OP_BYTES` bytes of A (MSB first), then `OP_BYTES` bytes of B (MSB first), then 1 opcode byte. Frame length is N = 2*`OP_BYTES`+1. Opcode bits [7:3] are ignored.
- FSM states:
  - RX: `rx_ready_o`=1. Each handshake shifts the byte into the A, B or op register by byte index 0..N-1. After the handshake of byte N-1 → EXEC.
  - EXEC: one cycle. The ALU sees registered operands; `alu_result_i` and `alu_flags_i` are captured into the shift register at the end of the cycle → TX.
  - TX: bytes are presented MSB first, `DW`/8 bytes, plus the flags byte when configured. The byte index advances on `tx_valid_o`&`tx_ready_i`. After the last handshake → RX and `frame_cnt_o`++.
- `rx_ready_o`=0 in EXEC and TX. Bytes offered then are not consumed, so upstream holds them.
- Sign extension: A and B are replicated from their bit 8*`OP_BYTES`-1 up to `DW`-1.
- `alu_a_o`, `alu_b_o` and `alu_op_o` hold their values from EXEC until the next frame overwrites them.
- Timeout: applies in RX with byte index >0. The idle counter increments each cycle without an rx handshake and clears on a handshake.
  - When the counter reaches `TIMEOUT_CYC`: byte index→0, `frame_drop_o` pulses, and A/B/op are left stale.
  - If a handshake coincides with the timeout cycle, the byte is taken as index 0 of a new frame.
- Reset values: `rx_ready_o`=0 during reset, 1 in the first cycle after release (state RX, index 0). `tx_valid_o`=0, `tx_data_o`=0, `alu_a_o`=`alu_b_o`=0, `alu_op_o`=0, `busy_o`=0, `frame_drop_o`=0, `frame_cnt_o`=0.
- Reset mid-frame or mid-TX aborts immediately. No partial output is resumed.

## Timing
- Last rx handshake at cycle T → EXEC at T+1 (`busy_o`=1, `alu_*_o` valid).
- First result byte has `tx_valid_o`=1 at T+2.
- With `tx_ready_i` held high, bytes leave one per cycle; the last byte is at T+1+`DW`/8 (+1 with flags).
- `rx_ready_o` returns to 1 the cycle after the final tx handshake.
- `tx_data_o` and `tx_valid_o` are stable while `tx_valid_o`&!`tx_ready_i`.
- `tx_valid_o` never deasserts without a handshake.
- All outputs are registered.

## Configuration
- `ALU_FLAGS_EN` defined: TX appends one trailing byte {4'b0, Z, C, N, V} captured in EXEC, giving `DW`/8+1 bytes per frame.
- `ALU_FLAGS_EN` undefined: `alu_flags_i` is unused and exactly `DW`/8 bytes are sent.

## Test plan
All scenarios use `OP_BYTES`=2, `DW`=32 and an adder model for the ALU.
- Basic add: rx 00 05 00 03 00 → `alu_a_o`=0x5, `alu_b_o`=0x3, `alu_op_o`=0; tx 00 00 00 08 with first byte at T+2; `frame_cnt_o`=1.
- Sign extension: rx FF FE 00 01 00 → `alu_a_o`=0xFFFFFFFE; tx FF FF FF FF.
- Back-pressure: `tx_ready_i`=0 for 10 cycles after the first valid byte → `tx_data_o` is held at 0x00, `rx_ready_o`=0 and `busy_o`=1 throughout; output completes once ready rises.
- Timeout resync with `TIMEOUT_CYC`=20: rx 12 34, idle 20 cycles → `frame_drop_o` pulses once, no tx. A following full frame 00 01 00 01 00 → tx 00 00 00 02.
- Reset mid-TX: assert `rst_n`=0 after 2 tx bytes → `tx_valid_o`=0 and `frame_cnt_o`=0 immediately. After release a new frame is processed normally.
- `ALU_FLAGS_EN`: rx 00 00 00 00 00 with model Z=1 → tx 00 00 00 00 08.

Source files
------------

// File: rtl/alu_frame_engine.sv
// Byte-stream command engine: assembles {A, B, op} frames for a combinational ALU and
// serialises the captured result MSB-first. Optional flags byte enabled by ALU_FLAGS_EN.
module alu_frame_engine #(
    parameter int unsigned OP_BYTES    = 2,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          rx_valid_i,
    output logic          rx_ready_o,
    input  logic [7:0]    rx_data_i,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic [7:0]    tx_data_o,
    output logic [DW-1:0] alu_a_o,
    output logic [DW-1:0] alu_b_o,
    output logic [2:0]    alu_op_o,
    input  logic [DW-1:0] alu_result_i,
    input  logic [3:0]    alu_flags_i,
    output logic          busy_o,
    output logic          frame_drop_o,
    output logic [15:0]   frame_cnt_o
);

    localparam int unsigned AW  = 8 * OP_BYTES;
    localparam int unsigned NB  = 2 * OP_BYTES + 1;
    localparam int unsigned IXW = $clog2(NB);
`ifdef ALU_FLAGS_EN
    localparam int unsigned TXB = DW / 8 + 1;
`else
    localparam int unsigned TXB = DW / 8;
`endif
    localparam int unsigned SW  = 8 * TXB;
    localparam int unsigned TXW = (TXB > 1) ? $clog2(TXB) : 1;
    localparam int unsigned TOW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [1:0] StRx   = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StTx   = 2'd2;

    logic [1:0]     r_state;
    logic [IXW-1:0] r_rx_idx;
    logic [TOW-1:0] r_idle;
    logic [AW-1:0]  r_a_asm;
    logic [AW-1:0]  r_b_asm;
    logic [DW-1:0]  r_alu_a;
    logic [DW-1:0]  r_alu_b;
    logic [2:0]     r_alu_op;
    logic [SW-1:0]  r_tx_sh;
    logic [TXW-1:0] r_tx_idx;
    logic           r_tx_valid;
    logic           r_rx_ready;
    logic           r_busy;
    logic           r_frame_drop;
    logic [15:0]    r_frame_cnt;

    logic [1:0]     w_state_nxt;
    logic [IXW-1:0] w_rx_idx_nxt;
    logic [TOW-1:0] w_idle_nxt;
    logic           w_rx_hs;
    logic           w_tx_hs;
    logic           w_tx_last;
    logic           w_timeout;
    logic [IXW-1:0] w_byte_idx;
    logic [DW-1:0]  w_a_ext;
    logic [DW-1:0]  w_b_ext;

    assign w_rx_hs   = rx_valid_i & r_rx_ready;
    assign w_tx_hs   = r_tx_valid & tx_ready_i;
    assign w_tx_last = w_tx_hs && (r_tx_idx == TXW'(TXB - 1));
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_state == StRx) && (r_rx_idx != '0) &&
                       (r_idle == TOW'(TIMEOUT_CYC));
    // A byte arriving in the timeout cycle starts a fresh frame.
    assign w_byte_idx = w_timeout ? '0 : r_rx_idx;
    assign w_a_ext    = DW'($signed(r_a_asm));
    assign w_b_ext    = DW'($signed(r_b_asm));

`ifndef ALU_FLAGS_EN
    logic w_unused_flags;
    assign w_unused_flags = ^alu_flags_i;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_rx_idx_nxt = r_rx_idx;
        w_idle_nxt   = r_idle;
        case (r_state)
            StRx: begin
                if (w_rx_hs) begin
                    w_idle_nxt = '0;
                    if (w_byte_idx == IXW'(NB - 1)) begin
                        w_state_nxt  = StExec;
                        w_rx_idx_nxt = '0;
                    end else begin
                        w_rx_idx_nxt = w_byte_idx + 1'b1;
                    end
                end else if (w_timeout) begin
                    w_rx_idx_nxt = '0;
                    w_idle_nxt   = '0;
                end else if (r_rx_idx != '0) begin
                    w_idle_nxt = r_idle + 1'b1;
                end else begin
                    w_idle_nxt = '0;
                end
            end
            StExec: w_state_nxt = StTx;
            StTx: begin
                if (w_tx_last) begin
                    w_state_nxt = StRx;
                end
            end
            default: w_state_nxt = StRx;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StRx;
            r_rx_idx     <= '0;
            r_idle       <= '0;
            r_rx_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_drop <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rx_idx     <= w_rx_idx_nxt;
            r_idle       <= w_idle_nxt;
            r_rx_ready   <= (w_state_nxt == StRx);
            r_busy       <= (w_state_nxt != StRx);
            r_frame_drop <= w_timeout;
        end
    end

    // Frame assembly; operands are published only once the opcode byte completes the frame.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_a_asm  <= '0;
            r_b_asm  <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
        end else if (w_rx_hs) begin
            if (w_byte_idx < IXW'(OP_BYTES)) begin
                r_a_asm <= (r_a_asm << 8) | AW'(rx_data_i);
            end else if (w_byte_idx < IXW'(2 * OP_BYTES)) begin
                r_b_asm <= (r_b_asm << 8) | AW'(rx_data_i);
            end else begin
                r_alu_a  <= w_a_ext;
                r_alu_b  <= w_b_ext;
                r_alu_op <= rx_data_i[2:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_sh     <= '0;
            r_tx_idx    <= '0;
            r_tx_valid  <= 1'b0;
            r_frame_cnt <= '0;
        end else if (r_state == StExec) begin
`ifdef ALU_FLAGS_EN
            r_tx_sh <= {alu_result_i, 4'b0000, alu_flags_i};
`else
            r_tx_sh <= alu_result_i;
`endif
            r_tx_idx   <= '0;
            r_tx_valid <= 1'b1;
        end else if (w_tx_hs) begin
            r_tx_sh  <= r_tx_sh << 8;
            r_tx_idx <= r_tx_idx + 1'b1;
            if (w_tx_last) begin
                r_tx_valid  <= 1'b0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign rx_ready_o   = r_rx_ready;
    assign tx_valid_o   = r_tx_valid;
    assign tx_data_o    = r_tx_sh[SW-1 -: 8];
    assign alu_a_o      = r_alu_a;
    assign alu_b_o      = r_alu_b;
    assign alu_op_o     = r_alu_op;
    assign busy_o       = r_busy;
    assign frame_drop_o = r_frame_drop;
    assign frame_cnt_o  = r_frame_cnt;

endmodule

// File: tb/tb_alu_frame_engine.sv
// Directed bench for alu_frame_engine with an adder ALU model; honours ALU_FLAGS_EN.
module tb_alu_frame_engine;

`ifdef ALU_FLAGS_EN
    localparam int NTX = 5;
`else
    localparam int NTX = 4;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  rx_data_i;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  tx_data_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [2:0]  alu_op_o;
    logic [31:0] alu_result_i;
    logic [3:0]  alu_flags_i;
    logic        busy_o;
    logic        frame_drop_o;
    logic [15:0] frame_cnt_o;

    always #5 clk_i = ~clk_i;

    alu_frame_engine #(
        .OP_BYTES   (2),
        .DW         (32),
        .TIMEOUT_CYC(20)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .rx_data_i   (rx_data_i),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .tx_data_o   (tx_data_o),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_op_o    (alu_op_o),
        .alu_result_i(alu_result_i),
        .alu_flags_i (alu_flags_i),
        .busy_o      (busy_o),
        .frame_drop_o(frame_drop_o),
        .frame_cnt_o (frame_cnt_o)
    );

    // Adder ALU model: {Z, C, N, V}
    logic [32:0] w_sum;
    assign w_sum        = {1'b0, alu_a_o} + {1'b0, alu_b_o};
    assign alu_result_i = w_sum[31:0];
    assign alu_flags_i  = {w_sum[31:0] == 32'd0, w_sum[32], w_sum[31],
                           (alu_a_o[31] == alu_b_o[31]) && (w_sum[31] != alu_a_o[31])};

    typedef struct {
        logic [39:0] rx;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    vec_t vt[6];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        for (int k = 0; k < 100; k++) begin
            if (rx_ready_o) break;
            tick();
        end
        if (!rx_ready_o) begin
            check("send_byte rx_ready wait", {63'd0, rx_ready_o}, 64'd1);
            rx_valid_i = 1'b0;
            return;
        end
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8]);
    endtask

    task automatic recv(input int n, output logic [39:0] got, output int first_lat,
                        output int span);
        int seen;
        seen       = 0;
        got        = '0;
        first_lat  = -1;
        span       = 0;
        tx_ready_i = 1'b1;
        for (int c = 0; c < 100 && seen < n; c++) begin
            if (tx_valid_o) begin
                if (seen == 0) first_lat = c;
                got  = {got[31:0], tx_data_o};
                seen = seen + 1;
                span = c - first_lat;
            end
            tick();
        end
        if (seen < n) check("recv byte count", 64'(seen), 64'(n));
    endtask

    function automatic logic [39:0] exp_tx(input logic [31:0] res, input logic [3:0] fl);
`ifdef ALU_FLAGS_EN
        return {res, 4'h0, fl};
`else
        return {8'h00, res} | 40'(fl & 4'h0);
`endif
    endfunction

    task automatic do_frame(input string name, input logic [39:0] f, input logic [31:0] ea,
                            input logic [31:0] eb, input logic [2:0] eop,
                            input logic [31:0] eres, input logic [3:0] efl);
        logic [39:0] got;
        int          fl_lat;
        int          sp;
        send_frame(f);
        check({name, " busy in EXEC"}, {63'd0, busy_o}, 64'd1);
        check({name, " tx_valid in EXEC"}, {63'd0, tx_valid_o}, 64'd0);
        check({name, " alu_a"}, {32'd0, alu_a_o}, {32'd0, ea});
        check({name, " alu_b"}, {32'd0, alu_b_o}, {32'd0, eb});
        check({name, " alu_op"}, {61'd0, alu_op_o}, {61'd0, eop});
        recv(NTX, got, fl_lat, sp);
        check({name, " first byte latency"}, 64'(fl_lat), 64'd1);
        check({name, " tx span"}, 64'(sp), 64'(NTX - 1));
        check({name, " tx bytes"}, {24'd0, got}, {24'd0, exp_tx(eres, efl)});
        exp_cnt++;
        check({name, " frame_cnt"}, {48'd0, frame_cnt_o}, 64'(exp_cnt));
        check({name, " rx_ready after tx"}, {63'd0, rx_ready_o}, 64'd1);
        check({name, " busy after tx"}, {63'd0, busy_o}, 64'd0);
    endtask

    initial begin
        logic [39:0] got;
        int          lat;
        int          sp;
        int          drops;
        int          txs;

        vt[0] = '{40'h00_05_00_03_00, 32'h0000_0005, 32'h0000_0003, 3'd0, 32'h0000_0008, 4'h0};
        vt[1] = '{40'hFF_FE_00_01_00, 32'hFFFF_FFFE, 32'h0000_0001, 3'd0, 32'hFFFF_FFFF, 4'h2};
        vt[2] = '{40'h7F_FF_00_01_F9, 32'h0000_7FFF, 32'h0000_0001, 3'd1, 32'h0000_8000, 4'h0};
        vt[3] = '{40'h80_00_80_00_07, 32'hFFFF_8000, 32'hFFFF_8000, 3'd7, 32'hFFFF_0000, 4'h6};
        vt[4] = '{40'h00_00_00_00_00, 32'h0000_0000, 32'h0000_0000, 3'd0, 32'h0000_0000, 4'h8};
        vt[5] = '{40'h12_34_FF_FF_05, 32'h0000_1234, 32'hFFFF_FFFF, 3'd5, 32'h0000_1233, 4'h4};

        rst_n      = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        tx_ready_i = 1'b0;
        repeat (3) tick();
        check("reset rx_ready", {63'd0, rx_ready_o}, 64'd0);
        check("reset tx_valid", {63'd0, tx_valid_o}, 64'd0);
        check("reset tx_data", {56'd0, tx_data_o}, 64'd0);
        check("reset alu_a", {32'd0, alu_a_o}, 64'd0);
        check("reset alu_b", {32'd0, alu_b_o}, 64'd0);
        check("reset alu_op", {61'd0, alu_op_o}, 64'd0);
        check("reset busy", {63'd0, busy_o}, 64'd0);
        check("reset frame_drop", {63'd0, frame_drop_o}, 64'd0);
        check("reset frame_cnt", {48'd0, frame_cnt_o}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("rx_ready after release", {63'd0, rx_ready_o}, 64'd1);

        for (int i = 0; i < 6; i++) begin
            do_frame($sformatf("vec%0d", i), vt[i].rx, vt[i].a, vt[i].b, vt[i].op,
                     vt[i].res, vt[i].fl);
        end

        // Back-pressure: first result byte held for 10 cycles while a stray rx byte is offered.
        tx_ready_i = 1'b0;
        send_frame(40'h00_05_00_03_00);
        for (int k = 0; k < 10 && !tx_valid_o; k++) tick();
        rx_valid_i = 1'b1;
        rx_data_i  = 8'hAA;
        for (int k = 0; k < 10; k++) begin
            check("bp tx_valid held", {63'd0, tx_valid_o}, 64'd1);
            check("bp tx_data held", {56'd0, tx_data_o}, 64'd0);
            check("bp rx_ready low", {63'd0, rx_ready_o}, 64'd0);
            check("bp busy high", {63'd0, busy_o}, 64'd1);
            tick();
        end
        rx_valid_i = 1'b0;
        recv(NTX, got, lat, sp);
        check("bp tx bytes", {24'd0, got}, {24'd0, exp_tx(32'h8, 4'h0)});
        exp_cnt++;
        check("bp frame_cnt", {48'd0, frame_cnt_o}, 64'(exp_cnt));

        // Timeout resync: partial frame is dropped exactly once, nothing transmitted.
        send_byte(8'h12);
        send_byte(8'h34);
        drops = 0;
        txs   = 0;
        for (int c = 0; c < 40; c++) begin
            if (frame_drop_o) drops++;
            if (tx_valid_o) txs++;
            tick();
        end
        check("timeout drop pulses", 64'(drops), 64'd1);
        check("timeout no tx", 64'(txs), 64'd0);
        check("timeout frame_cnt", {48'd0, frame_cnt_o}, 64'(exp_cnt));
        do_frame("resync", 40'h00_01_00_01_00, 32'h1, 32'h1, 3'd0, 32'h2, 4'h0);

        // Reset after two result bytes aborts the frame immediately.
        send_frame(40'h00_07_00_01_00);
        tx_ready_i = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mid-tx reset tx_valid", {63'd0, tx_valid_o}, 64'd0);
        check("mid-tx reset frame_cnt", {48'd0, frame_cnt_o}, 64'd0);
        check("mid-tx reset busy", {63'd0, busy_o}, 64'd0);
        check("mid-tx reset rx_ready", {63'd0, rx_ready_o}, 64'd0);
        exp_cnt = 0;
        tick();
        rst_n = 1'b1;
        tick();
        do_frame("post-reset", 40'h00_07_00_01_00, 32'h7, 32'h1, 3'd0, 32'h8, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
